// File: rtl/bomb_sequencer_if.sv
// Bundle between the bomb game controller and its environment: keypad, secret code,
// timer digit feedback, timer controls and round status.
interface bomb_sequencer_if;
  logic        start;
  logic [15:0] secret_code;
  logic [3:0]  digit;
  logic        digit_valid;
  logic [3:0]  value_three;
  logic [3:0]  value_two;
  logic [3:0]  value_one;
  logic        switch_op;
  logic        sec_timer;
  logic [1:0]  strikes;
  logic        armed;
  logic        defused;
  logic        exploded;

  modport master (
    output start, secret_code, digit, digit_valid, value_three, value_two, value_one,
    input  switch_op, sec_timer, strikes, armed, defused, exploded
  );

  modport slave (
    input  start, secret_code, digit, digit_valid, value_three, value_two, value_one,
    output switch_op, sec_timer, strikes, armed, defused, exploded
  );
endinterface

// File: rtl/bomb_sequencer.sv
// Bomb round controller: arms the BCD timer, generates the second tick, checks the keypad code.
// All outputs registered; decisions on a sampled input are visible one cycle later.
module bomb_sequencer #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned MAX_STRIKES   = 3
) (
  input  logic             clk,
  input  logic             reset,
  bomb_sequencer_if.slave  bus
);
  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DEFUSED, EXPLODED} state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   code_q;
  logic [2:0]    cnt_q;
  logic [1:0]    strikes_q;
  logic          switch_op_q;
  logic          sec_timer_q;
  logic          armed_q;
  logic          defused_q;
  logic          exploded_q;

  logic [31:0]   tick_limit;
  logic          wrap;
  logic          digit_ok;
  logic          timeout;
  logic [15:0]   code_d;
  logic [1:0]    strikes_d;

  // Each strike halves the prescaler period, floored at 2 so ticks never merge.
  always_comb begin
    tick_limit = 32'(TICKS_PER_SEC) >> strikes_q;
    if (tick_limit < 32'd2) tick_limit = 32'd2;
  end

  // >= rather than == so a shrunken limit still wraps promptly.
  assign wrap      = 32'(presc_q) >= (tick_limit - 32'd1);
  assign digit_ok  = bus.digit_valid && (bus.digit <= 4'd9);
  assign timeout   = sec_timer_q && (bus.value_three == 4'd0) &&
                     (bus.value_two == 4'd0) && (bus.value_one == 4'd0);
  assign code_d    = {code_q[11:0], bus.digit};
  assign strikes_d = strikes_q + 2'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      code_q      <= '0;
      cnt_q       <= '0;
      strikes_q   <= '0;
      switch_op_q <= 1'b0;
      sec_timer_q <= 1'b0;
      armed_q     <= 1'b0;
      defused_q   <= 1'b0;
      exploded_q  <= 1'b0;
    end else begin
      switch_op_q <= 1'b0;
      sec_timer_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            switch_op_q <= 1'b1;
            presc_q     <= '0;
            code_q      <= '0;
            cnt_q       <= '0;
            armed_q     <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          presc_q     <= wrap ? '0 : presc_q + 1'b1;
          sec_timer_q <= wrap;
          if (timeout) begin
            // Timer reinitialises itself on this tick; a switch_op here would reload it.
            sec_timer_q <= 1'b0;
            armed_q     <= 1'b0;
            exploded_q  <= 1'b1;
            state_q     <= EXPLODED;
          end else if (digit_ok) begin
            code_q <= code_d;
            if (cnt_q == 3'd3) begin
              if (code_d == bus.secret_code) begin
                cnt_q       <= 3'd4;
                switch_op_q <= 1'b1;
                sec_timer_q <= 1'b0;
                armed_q     <= 1'b0;
                defused_q   <= 1'b1;
                state_q     <= DEFUSED;
              end else begin
                cnt_q     <= '0;
                strikes_q <= strikes_d;
                if (strikes_d == 2'(MAX_STRIKES)) begin
                  switch_op_q <= 1'b1;
                  sec_timer_q <= 1'b0;
                  armed_q     <= 1'b0;
                  exploded_q  <= 1'b1;
                  state_q     <= EXPLODED;
                end
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        default: begin
          // DEFUSED and EXPLODED hold until reset.
        end
      endcase
    end
  end

  assign bus.switch_op = switch_op_q;
  assign bus.sec_timer = sec_timer_q;
  assign bus.strikes   = strikes_q;
  assign bus.armed     = armed_q;
  assign bus.defused   = defused_q;
  assign bus.exploded  = exploded_q;
endmodule

// File: tb/tb_bomb_sequencer.sv
// Bench for bomb_sequencer with a behavioural BCD countdown timer attached to its controls.
module tb_bomb_sequencer;
  localparam int TPS  = 8;
  localparam int MAXS = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bomb_sequencer_if bus();

  bomb_sequencer #(.TICKS_PER_SEC(TPS), .MAX_STRIKES(MAXS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  // Timer: switch_op loads init when idle and stops/clears when running;
  // a tick at zero returns it to the idle, cleared state.
  int tmr_init = 0;
  int tmr_val;
  bit tmr_run;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_run <= 1'b0;
      tmr_val <= 0;
    end else if (bus.switch_op) begin
      if (!tmr_run) begin
        tmr_run <= 1'b1;
        tmr_val <= tmr_init;
      end else begin
        tmr_run <= 1'b0;
        tmr_val <= 0;
      end
    end else if (bus.sec_timer && tmr_run) begin
      if (tmr_val == 0) tmr_run <= 1'b0;
      else tmr_val <= tmr_val - 1;
    end
  end

  always_comb begin
    bus.value_three = 4'(tmr_val / 100);
    bus.value_two   = 4'((tmr_val / 10) % 10);
    bus.value_one   = 4'(tmr_val % 10);
  end

  // Observation 1 time unit after each rising edge.
  int cyc = 0;
  int sw_cnt = 0;
  int ovl = 0;
  int tick_t[$];
  int tick_v[$];
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (bus.sec_timer) begin
      tick_t.push_back(cyc);
      tick_v.push_back(tmr_val);
    end
    if (bus.switch_op) sw_cnt++;
    if (bus.switch_op && bus.sec_timer) ovl++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int limit_of(input int s);
    int l;
    l = TPS >> s;
    return (l < 2) ? 2 : l;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    bus.digit       = d;
    bus.digit_valid = 1'b1;
    @(negedge clk);
    bus.digit_valid = 1'b0;
  endtask

  task automatic key_gap(input logic [3:0] d);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    key(d);
  endtask

  task automatic wrong_code();
    logic [3:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = 4'($urandom_range(0, 9));
    if (d[0] == 4'd1 && d[1] == 4'd2 && d[2] == 4'd3 && d[3] == 4'd4) d[3] = 4'd5;
    for (int i = 0; i < 4; i++) key_gap(d[i]);
  endtask

  task automatic next_tick(output int c, output bit ok);
    ok = 1'b0;
    c  = 0;
    for (int i = 0; i < 4 * TPS && !ok; i++) begin
      @(negedge clk);
      if (bus.sec_timer) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
  endtask

  task automatic check_period(input string tag, input int s);
    int c1, c2, c3;
    bit o1, o2, o3;
    next_tick(c1, o1);
    next_tick(c2, o2);
    next_tick(c3, o3);
    chk({tag, "_seen"}, 32'(o1 & o2 & o3), 1);
    chk(tag, c3 - c2, limit_of(s));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_switch_op"}, bus.switch_op, 0);
    chk({tag, "_sec_timer"}, bus.sec_timer, 0);
    chk({tag, "_strikes"},   bus.strikes,   0);
    chk({tag, "_armed"},     bus.armed,     0);
    chk({tag, "_defused"},   bus.defused,   0);
    chk({tag, "_exploded"},  bus.exploded,  0);
  endtask

  initial begin
    int  init, e, xc, sw0, exp_s, c1, n;
    bit  ok;
    bus.start       = 1'b0;
    bus.digit       = 4'd0;
    bus.digit_valid = 1'b0;
    bus.secret_code = 16'h1234;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1;
    @(negedge clk);

    // Keypad ignored while idle
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk("idle_armed", bus.armed, 0);
    chk("idle_defused", bus.defused, 0);
    chk("idle_sw", sw_cnt, 0);

    // Arm and run out of time
    init = int'($urandom_range(1, 4));
    tmr_init = init;
    tick_t.delete();
    tick_v.delete();
    pulse_start();
    chk("arm_switch_op", bus.switch_op, 1);
    chk("arm_armed", bus.armed, 1);
    e  = cyc;
    ok = 1'b0;
    xc = 0;
    for (int i = 0; i < TPS * 8 + 16 && !ok; i++) begin
      @(negedge clk);
      if (bus.exploded) begin
        ok = 1'b1;
        xc = cyc;
      end
    end
    chk("arm_explode_seen", 32'(ok), 1);
    chk("arm_explode_cyc", xc, e + TPS * (init + 1) + 1);
    chk("arm_tick_count", tick_t.size(), init + 1);
    for (int k = 0; k < tick_t.size() && k <= init; k++) begin
      chk("arm_tick_cyc", tick_t[k], e + TPS * (k + 1));
      chk("arm_tick_val", tick_v[k], init - k);
    end
    chk("arm_sw_total", sw_cnt, 1);
    chk("arm_armed_end", bus.armed, 0);
    chk("arm_defused_end", bus.defused, 0);

    // Defuse, with an out-of-range digit that must not count
    do_reset();
    tmr_init = 120;
    sw0 = sw_cnt;
    pulse_start();
    repeat ($urandom_range(3, 20)) @(negedge clk);
    key_gap(4'd1); key_gap(4'd2); key_gap(4'd3); key_gap(4'hA); key_gap(4'd4);
    chk("def_switch_op", bus.switch_op, 1);
    chk("def_defused", bus.defused, 1);
    chk("def_armed", bus.armed, 0);
    chk("def_exploded", bus.exploded, 0);
    @(negedge clk);
    chk("def_timer_zero", {bus.value_three, bus.value_two, bus.value_one}, 0);
    n = tick_t.size();
    repeat (5 * TPS) @(negedge clk);
    chk("def_no_ticks", tick_t.size(), n);
    pulse_start();
    @(negedge clk);
    chk("def_start_ignored", sw_cnt, sw0 + 2);
    chk("def_still_defused", bus.defused, 1);
    chk("def_still_idle", bus.armed, 0);

    // Strikes speed up the tick
    do_reset();
    tmr_init = 120;
    pulse_start();
    check_period("period_s0", 0);
    exp_s = 0;
    for (int s = 1; s <= 2; s++) begin
      sw0 = sw_cnt;
      wrong_code();
      exp_s++;
      chk("strike_count", bus.strikes, 32'(exp_s));
      chk("strike_armed", bus.armed, 1);
      chk("strike_no_sw", sw_cnt, sw0);
      check_period("strike_period", exp_s);
    end

    // Asynchronous reset mid-round
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Re-arm, then strike out
    tmr_init = 120;
    pulse_start();
    chk("rearm_switch_op", bus.switch_op, 1);
    chk("rearm_armed", bus.armed, 1);
    sw0 = sw_cnt;
    exp_s = 0;
    for (int s = 1; s <= MAXS; s++) begin
      wrong_code();
      exp_s++;
      chk("so_strikes", bus.strikes, 32'(exp_s));
      chk("so_exploded", bus.exploded, (exp_s == MAXS) ? 1 : 0);
      chk("so_switch_op", bus.switch_op, (exp_s == MAXS) ? 1 : 0);
    end
    chk("so_sw_total", sw_cnt, sw0 + 1);
    key(4'd1);
    repeat (4) @(negedge clk);
    chk("so_strikes_frozen", bus.strikes, 32'(MAXS));

    // 4th correct digit lands on the tick at 000
    do_reset();
    tmr_init = 1;
    sw0 = sw_cnt;
    pulse_start();
    next_tick(c1, ok);
    chk("coll_first_tick", 32'(ok), 1);
    key(4'd1); key(4'd2); key(4'd3);
    while (cyc < c1 + TPS) @(negedge clk);
    chk("coll_tick_now", bus.sec_timer, 1);
    chk("coll_timer_zero", {bus.value_three, bus.value_two, bus.value_one}, 0);
    key(4'd4);
    chk("coll_exploded", bus.exploded, 1);
    chk("coll_defused", bus.defused, 0);
    chk("coll_switch_op", bus.switch_op, 0);
    chk("coll_sw_total", sw_cnt, sw0 + 1);

    chk("no_overlap", ovl, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/bomb_sequencer.md
# bomb_sequencer

Top-level game controller that sequences the BCD countdown timer in the bomb datapath. It arms the timer on a start pulse and generates the one-second tick. It collects a 4-digit defuse code from the keypad and tracks wrong-code strikes. It declares the round defused or exploded. It drives the timer only through that timer's existing `switch_op`/`sec_timer` controls and observes the timer's three BCD digit outputs.

## Interface
- `TICKS_PER_SEC`, default 50000000: clk cycles per nominal second; must be ≥ 8.
- `MAX_STRIKES`, default 3: wrong codes that cause explosion; range 1..3.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse requesting arm.
- `secret_code`  in  16  four BCD digits; [15:12] is the first digit entered.
- `digit`  in  4  keypad BCD digit.
- `digit_valid`  in  1  one-cycle strobe qualifying `digit`.
- `value_three`, `value_two`, `value_one`  in  4 each  timer BCD digits, hundreds/tens/ones.
- `switch_op`  out  1  registered one-cycle pulse to the timer.
- `sec_timer`  out  1  registered one-cycle tick to the timer.
- `strikes`  out  2  wrong-code count.
- `armed`  out  1  high in RUN.
- `defused`  out  1  high in DEFUSED.
- `exploded`  out  1  high in EXPLODED.

## Operation
- **States:** IDLE, RUN, DEFUSED, EXPLODED.
- **IDLE:**
  - `digit_valid` is ignored.
  - On `start`=1: pulse `switch_op` for one cycle (the timer loads its initial time), clear the prescaler and entry buffer, and go to RUN.
- **RUN, prescaler:**
  - Counts 0..LIMIT-1, then wraps to 0.
  - LIMIT = max(TICKS_PER_SEC >> strikes, 2), so each strike doubles the tick rate.
  - `sec_timer` pulses in the cycle the prescaler wraps.
- **RUN, code entry:**
  - A `digit_valid` with `digit` ≤ 9 shifts the digit into a 16-bit buffer, MSB-first, and increments a 0..4 entry count.
  - Digits > 9 are ignored.
  - On the 4th accepted digit, the buffer including that digit is compared with `secret_code`.
- **RUN, match:**
  - Pulse `switch_op` (stops the timer) and go to DEFUSED.
- **RUN, mismatch:**
  - `strikes`+1 and clear the entry count.
  - If the new strike count equals MAX_STRIKES: pulse `switch_op` and go to EXPLODED.
  - Otherwise stay in RUN. The prescaler is not restarted, but the new LIMIT applies from the next wrap.
- **RUN, timeout:**
  - If a `sec_timer` pulse is issued while `value_three`, `value_two` and `value_one` are all 0, go to EXPLODED.
  - No `switch_op` pulse on this path: the timer returns to its init state by itself on that tick, and a `switch_op` there would reload it.
- **Simultaneous timeout and 4th digit in the same cycle:** timeout wins. EXPLODED, no compare, no `switch_op`.
- **DEFUSED and EXPLODED:** terminal until `reset`. `start` and `digit_valid` are ignored; `strikes` is frozen.
- **Reset value of every output:** `switch_op`=0, `sec_timer`=0, `strikes`=0, `armed`=0, `defused`=0, `exploded`=0. State is IDLE; prescaler and entry count are 0.
- **Reset mid-round:** asynchronous return to IDLE. The timer shares the `reset` net and clears itself.

## Timing
- `start` sampled at edge N → `switch_op`=1 during cycle N+1 → timer loads at edge N+2. `armed`=1 from cycle N+1.
- First `sec_timer` pulse is LIMIT cycles after RUN entry. Thereafter `sec_timer` has period LIMIT, pulse width exactly 1 cycle.
- 4th digit sampled at edge M → `switch_op` pulse and DEFUSED/EXPLODED status visible in cycle M+1.
- `strikes` update is also visible in cycle M+1.
- The timer values sampled for the zero check are the registered values present in the tick cycle.
- `switch_op` and `sec_timer` are never high in the same cycle.
- Prescaler width is $clog2(TICKS_PER_SEC).

## Test plan
All scenarios use TICKS_PER_SEC=8, secret_code=16'h1234, and a real timer instance.
- **Arm:** init time 0x003; `start` → `switch_op` 1 cycle; ticks every 8 cycles; digits go 3, 2, 1, 0; the tick at 0 gives `exploded`=1 with no `switch_op`.
- **Defuse:** init 0x120; enter 1, 2, 3, 4 mid-count → `switch_op` pulse, `defused`=1, timer digits 0; later ticks absent.
- **Strikes and speedup:**
  - Enter 1,2,3,5 → `strikes`=1, tick period becomes 4.
  - Second wrong code → `strikes`=2, period 2.
  - Third wrong code → `exploded`=1 with a `switch_op` pulse.
- **Edge inputs:** `digit` 0xA ignored (entry count unchanged); `digit_valid` in IDLE ignored; `start` in DEFUSED ignored.
- **Collision:** the 4th correct digit coincides with the tick at 000 → `exploded`=1, `defused`=0.
- **Reset:** assert `reset` mid-RUN with `strikes`=2 → all outputs 0 immediately (asynchronous); a subsequent `start` re-arms.
